step_pulse_gen: RTL and testbench

Stepper-motor step pulse generator: the consuming end of the tracking controller's step interface. It turns the controller's step period, direction and enable into clean STEP/DIR/ENABLE signals for the external stepper driver, and keeps a signed step-position count. It enforces pulse width, minimum period and direction-setup time, and never emits runt pulses on enable or direction changes.

---
 rtl/step_pulse_gen.sv | 122 ++++++++++++
 tb/tb_step_pulse_gen.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/step_pulse_gen.sv
// Stepper STEP/DIR/ENABLE generator with pulse-width, minimum-period and
// direction-setup enforcement plus a signed step-position counter.
module step_pulse_gen #(
  parameter int WIDTH_WORK  = 16,
  parameter int POS_WIDTH   = 32,
  parameter int PULSE_WIDTH = 100,
  parameter int N_MIN       = 200,
  parameter int DIR_SETUP   = 250
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        drv_enable_SM,
  input  logic                        drv_dir,
  input  logic [WIDTH_WORK-1:0]       N,
  output logic                        drv_step,
  output logic                        drv_dir_out,
  output logic                        drv_en_out,
  output logic                        step_tick,
  output logic                        busy,
  output logic signed [POS_WIDTH-1:0] position,
  output logic [1:0]                  state_dbg
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIR_WAIT = 2'd1,
    STEP_HI  = 2'd2,
    STEP_LO  = 2'd3
  } state_t;

  localparam logic [WIDTH_WORK-1:0] ONE     = WIDTH_WORK'(1);
  localparam logic [WIDTH_WORK-1:0] PW_W    = WIDTH_WORK'(PULSE_WIDTH);
  localparam logic [WIDTH_WORK-1:0] PW_LAST = WIDTH_WORK'(PULSE_WIDTH - 1);
  localparam logic [WIDTH_WORK-1:0] DS_LAST = WIDTH_WORK'(DIR_SETUP);
  localparam logic [WIDTH_WORK-1:0] N_MIN_W = WIDTH_WORK'(N_MIN);
  localparam logic signed [POS_WIDTH-1:0] POS_ONE = POS_WIDTH'(1);

  state_t                state;
  logic [WIDTH_WORK-1:0] cnt;
  logic [WIDTH_WORK-1:0] period;
  logic [WIDTH_WORK-1:0] n_eff;
  logic [WIDTH_WORK-1:0] lo_last;
  logic                  go;
  logic                  dir_match;
  logic                  hi_done;
  logic                  lo_done;
  logic                  dw_done;
  logic                  boundary;
  logic                  start_hi;
  logic                  start_dw;

  assign go        = drv_enable_SM && (N != '0);
  assign n_eff     = (N < N_MIN_W) ? N_MIN_W : N;
  assign lo_last   = period - PW_W - ONE;
  assign dir_match = (drv_dir == drv_dir_out);
  assign hi_done   = (cnt == PW_LAST);
  assign lo_done   = (cnt == lo_last);
  assign dw_done   = (cnt == DS_LAST);

  // A step boundary is IDLE or the last cycle of the low phase; both make the
  // same go/direction decision.
  assign boundary = (state == IDLE) || ((state == STEP_LO) && lo_done);
  assign start_hi = go && ((boundary && dir_match) || ((state == DIR_WAIT) && dw_done));
  assign start_dw = go && boundary && !dir_match;

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      period      <= '0;
      drv_step    <= 1'b0;
      drv_dir_out <= 1'b0;
      drv_en_out  <= 1'b0;
      step_tick   <= 1'b0;
      position    <= '0;
    end else begin
      drv_en_out <= drv_enable_SM;
      step_tick  <= start_hi;
      if (start_hi) begin
        state    <= STEP_HI;
        drv_step <= 1'b1;
        period   <= n_eff;
        cnt      <= '0;
        position <= drv_dir_out ? position + POS_ONE : position - POS_ONE;
      end else if (start_dw) begin
        state       <= DIR_WAIT;
        drv_dir_out <= drv_dir;
        cnt         <= '0;
      end else begin
        case (state)
          IDLE: cnt <= '0;
          // The high phase always runs to completion so no runt pulse escapes.
          STEP_HI: begin
            if (hi_done) begin
              state    <= STEP_LO;
              drv_step <= 1'b0;
              cnt      <= '0;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          STEP_LO, DIR_WAIT: begin
            if (!drv_enable_SM || ((state == STEP_LO) ? lo_done : dw_done)) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen: reset, latency, steady run, clamp,
// enable drop, direction reversal, period change and position wrap.
module tb_step_pulse_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        dir = 1'b0;
  logic [15:0] n   = 16'd0;
  logic        drv_step, drv_dir_out, drv_en_out, step_tick, busy;
  logic signed [31:0] position;
  logic [1:0]  state_dbg;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // ---------------- clock / reset ----------------
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(20 * 200000);
    $display("FAIL watchdog: simulation exceeded 200000 cycles");
    $fatal(1);
  end

  step_pulse_gen dut (
    .clk(clk), .rst(rst), .drv_enable_SM(en), .drv_dir(dir), .N(n),
    .drv_step(drv_step), .drv_dir_out(drv_dir_out), .drv_en_out(drv_en_out),
    .step_tick(step_tick), .busy(busy), .position(position), .state_dbg(state_dbg)
  );

  // ---------------- output monitor (records, does not judge) ----------------
  logic prev_step = 1'b0;
  logic prev_dir  = 1'b0;
  int   rise_cnt  = 0;
  int   last_rise = 0;
  int   tick_err  = 0;
  int   dir_err   = 0;
  int   rise_q[$];
  int   hi_q[$];
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    if (drv_step && !prev_step) begin
      rise_cnt++;
      last_rise = cyc;
      rise_q.push_back(cyc);
    end
    if (!drv_step && prev_step) hi_q.push_back(cyc - last_rise);
    if (step_tick !== (drv_step && !prev_step)) tick_err++;
    if ((drv_dir_out !== prev_dir) && (drv_step || prev_step)) dir_err++;
    prev_step = drv_step;
    prev_dir  = drv_dir_out;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rise(input int budget, output int t);
    int start;
    start = rise_cnt;
    t = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (rise_cnt != start) begin
        t = last_rise;
        break;
      end
    end
  endtask

  task automatic wait_low(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!drv_step) break;
      tick();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int c0, t;
    repeat (2) tick();
    checks++; if (drv_step !== 1'b0) begin errors++; $display("FAIL rst_step: got %b want 0", drv_step); end
    checks++; if (drv_dir_out !== 1'b0) begin errors++; $display("FAIL rst_dir: got %b want 0", drv_dir_out); end
    checks++; if (drv_en_out !== 1'b0) begin errors++; $display("FAIL rst_en: got %b want 0", drv_en_out); end
    checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL rst_tick: got %b want 0", step_tick); end
    checks++; if (position !== 32'd0) begin errors++; $display("FAIL rst_pos: got %0d want 0", position); end
    rst = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || state_dbg !== 2'd0) begin errors++; $display("FAIL rst_idle: busy %b state %0d want 0/0", busy, state_dbg); end
    // Reset in the middle of a high phase.
    c0 = cyc; en = 1'b1; n = 16'd1000; dir = 1'b0;
    wait_rise(10, t);
    checks++; if (t !== c0 + 1) begin errors++; $display("FAIL rst_pre_rise: got %0d want %0d", t, c0 + 1); end
    repeat (20) tick();
    rst = 1'b1;
    #1;
    checks++; if (drv_step !== 1'b0 || busy !== 1'b0 || drv_en_out !== 1'b0) begin
      errors++; $display("FAIL rst_mid_pulse: step %b busy %b en %b want 0/0/0", drv_step, busy, drv_en_out); end
    checks++; if (position !== 32'd0) begin errors++; $display("FAIL rst_mid_pos: got %0d want 0", position); end
    en = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_release_busy: got %b want 0", busy); end
    rise_q.delete(); hi_q.delete();
  endtask

  task automatic test_wrap_enable_hi();
    int c0, t, r;
    c0 = cyc; en = 1'b1; n = 16'd1000; dir = 1'b0;
    wait_rise(10, t);
    checks++; if (t !== c0 + 1) begin errors++; $display("FAIL first_latency: got %0d want %0d", t, c0 + 1); end
    checks++; if (position !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_pos: got %h want ffffffff", position); end
    r = rise_cnt;
    repeat (9) tick();
    en = 1'b0;
    wait_low(200);
    checks++; if (hi_q.size() == 0 || hi_q[$] !== 100) begin errors++; $display("FAIL en_drop_hi_width: got %0d want 100", (hi_q.size() == 0) ? -1 : hi_q[$]); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_drop_hi_idle: busy %b want 0", busy); end
    repeat (1500) tick();
    checks++; if (rise_cnt !== r) begin errors++; $display("FAIL en_drop_hi_extra: rises %0d want %0d", rise_cnt, r); end
    checks++; if (position !== 32'hFFFF_FFFF) begin errors++; $display("FAIL en_drop_hi_pos: got %h want ffffffff", position); end
  endtask

  task automatic test_dir_change_idle();
    int c0, t, r;
    c0 = cyc; en = 1'b1; n = 16'd1000; dir = 1'b1;
    tick();
    checks++; if (drv_dir_out !== 1'b1 || drv_step !== 1'b0) begin errors++; $display("FAIL dir_update: dir %b step %b want 1/0", drv_dir_out, drv_step); end
    wait_rise(400, t);
    checks++; if (t !== c0 + 252) begin errors++; $display("FAIL dir_setup_latency: got %0d want %0d", t, c0 + 252); end
    checks++; if (position !== 32'd0) begin errors++; $display("FAIL dir_pos: got %0d want 0", position); end
    // Enable drop during the low phase.
    wait_low(200);
    repeat (50) tick();
    en = 1'b0;
    r = rise_cnt;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_drop_lo_idle: busy %b want 0", busy); end
    repeat (1200) tick();
    checks++; if (rise_cnt !== r) begin errors++; $display("FAIL en_drop_lo_extra: rises %0d want %0d", rise_cnt, r); end
  endtask

  task automatic test_steady();
    int c0, r0, act;
    rise_q.delete(); hi_q.delete();
    r0 = rise_cnt;
    c0 = cyc; en = 1'b1; n = 16'd1000; dir = 1'b1;
    for (int i = 0; i < 10; i++) exp_q.push_back(32'(c0 + 1 + 1000 * i));
    repeat (10000) tick();
    en = 1'b0;
    repeat (1200) tick();
    checks++; if (rise_cnt - r0 !== 10) begin errors++; $display("FAIL steady_count: got %0d want 10", rise_cnt - r0); end
    while (exp_q.size() > 0) begin
      act = (rise_q.size() > 0) ? rise_q.pop_front() : -1;
      checks++; if (32'(act) !== exp_q[0]) begin errors++; $display("FAIL steady_rise: got %0d want %0d", act, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    checks++; if (hi_q.size() !== 10) begin errors++; $display("FAIL steady_hi_count: got %0d want 10", hi_q.size()); end
    foreach (hi_q[i]) begin
      checks++; if (hi_q[i] !== 100) begin errors++; $display("FAIL steady_hi_width[%0d]: got %0d want 100", i, hi_q[i]); end
    end
    checks++; if (position !== 32'd10) begin errors++; $display("FAIL steady_pos: got %0d want 10", position); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL steady_idle: busy %b want 0", busy); end
  endtask

  task automatic test_clamp();
    int c0, t0, t1, t2, r, bz;
    c0 = cyc; en = 1'b1; n = 16'd50; dir = 1'b1;
    wait_rise(10, t0);
    wait_rise(400, t1);
    wait_rise(400, t2);
    checks++; if (t0 !== c0 + 1) begin errors++; $display("FAIL clamp_rise0: got %0d want %0d", t0, c0 + 1); end
    checks++; if (t1 !== c0 + 201) begin errors++; $display("FAIL clamp_rise1: got %0d want %0d", t1, c0 + 201); end
    checks++; if (t2 !== c0 + 401) begin errors++; $display("FAIL clamp_rise2: got %0d want %0d", t2, c0 + 401); end
    n = 16'd0;
    r = rise_cnt;
    wait_low(200);
    checks++; if (hi_q.size() == 0 || hi_q[$] !== 100) begin errors++; $display("FAIL clamp_hi_width: got %0d want 100", (hi_q.size() == 0) ? -1 : hi_q[$]); end
    repeat (300) tick();
    checks++; if (rise_cnt !== r || busy !== 1'b0) begin errors++; $display("FAIL n0_stop: rises %0d busy %b want %0d/0", rise_cnt, busy, r); end
    checks++; if (position !== 32'd13) begin errors++; $display("FAIL clamp_pos: got %0d want 13", position); end
    bz = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (busy) bz++;
    end
    checks++; if (bz !== 0 || rise_cnt !== r) begin errors++; $display("FAIL n0_idle: busy cycles %0d rises %0d want 0/%0d", bz, rise_cnt, r); end
    en = 1'b0;
    tick();
  endtask

  task automatic test_reversal_and_n_change();
    int c0, t;
    c0 = cyc; en = 1'b1; n = 16'd1000; dir = 1'b1;
    wait_rise(10, t);
    checks++; if (t !== c0 + 1) begin errors++; $display("FAIL rev_rise0: got %0d want %0d", t, c0 + 1); end
    repeat (300) tick();
    dir = 1'b0;
    while (cyc < c0 + 1000) tick();
    checks++; if (drv_dir_out !== 1'b1) begin errors++; $display("FAIL rev_dir_hold: got %b want 1", drv_dir_out); end
    tick();
    checks++; if (drv_dir_out !== 1'b0 || drv_step !== 1'b0) begin errors++; $display("FAIL rev_dir_switch: dir %b step %b want 0/0", drv_dir_out, drv_step); end
    wait_rise(2000, t);
    checks++; if (t !== c0 + 1252) begin errors++; $display("FAIL rev_gap: got %0d want %0d", t, c0 + 1252); end
    checks++; if (position !== 32'd13) begin errors++; $display("FAIL rev_pos: got %0d want 13", position); end
    repeat (500) tick();
    n = 16'd400;
    wait_rise(2000, t);
    checks++; if (t !== c0 + 2252) begin errors++; $display("FAIL nchg_current: got %0d want %0d", t, c0 + 2252); end
    checks++; if (position !== 32'd12) begin errors++; $display("FAIL nchg_pos1: got %0d want 12", position); end
    wait_rise(2000, t);
    checks++; if (t !== c0 + 2652) begin errors++; $display("FAIL nchg_next: got %0d want %0d", t, c0 + 2652); end
    checks++; if (position !== 32'd11) begin errors++; $display("FAIL nchg_pos2: got %0d want 11", position); end
    en = 1'b0;
    repeat (500) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nchg_idle: busy %b want 0", busy); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_wrap_enable_hi();
    test_dir_change_idle();
    test_steady();
    test_clamp();
    test_reversal_and_n_change();
    checks++; if (tick_err !== 0) begin errors++; $display("FAIL step_tick_align: bad cycles %0d want 0", tick_err); end
    checks++; if (dir_err !== 0) begin errors++; $display("FAIL dir_while_step: events %0d want 0", dir_err); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
